// File: rtl/qdec.sv
// Quadrature decoder: per-channel synchroniser and glitch filter, Gray-code
// transition decode at X1/X2/X4 resolution, wrapping position and error flag.
module qdec #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 4,
   parameter string       MODE        = "X4",
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 sclr,
   input  logic                 a_in,
   input  logic                 b_in,
   input  logic                 pos_clr,
   output logic                 step,
   output logic                 dir,
   output logic                 err,
   output logic                 err_flag,
   output logic [CNT_WIDTH-1:0] pos
);

   localparam int unsigned FCNT_W   = $clog2(FILT_LEN + 1);
   localparam int unsigned INIT_LEN = SYNC_STAGES + FILT_LEN + 1;
   localparam int unsigned INIT_W   = $clog2(INIT_LEN + 1);
   localparam int unsigned RES      = (MODE == "X1") ? 1 : (MODE == "X2") ? 2 : 4;

   localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_LEN - 1);
   localparam logic [INIT_W-1:0] INIT_VAL  = INIT_W'(INIT_LEN);

   logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
   logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
   logic [1:0]             sync_ab;
   logic [1:0]             filt_q, filt_d;
   logic [FCNT_W-1:0]      fcnt_q [2];
   logic [FCNT_W-1:0]      fcnt_d [2];
   logic [1:0]             prev_q, prev_d;
   logic [INIT_W-1:0]      init_q, init_d;
   logic                   step_q, step_d;
   logic                   dir_q, dir_d;
   logic                   err_q, err_d;
   logic                   err_flag_q, err_flag_d;
   logic [CNT_WIDTH-1:0]   pos_q, pos_d;
   logic [1:0]             delta;
   logic                   counted;

   // Position of a {A,B} state along the forward Gray sequence 00-10-11-01
   function automatic logic [1:0] gray_idx(input logic [1:0] ab);
      case (ab)
         2'b00:   gray_idx = 2'd0;
         2'b10:   gray_idx = 2'd1;
         2'b11:   gray_idx = 2'd2;
         default: gray_idx = 2'd3;
      endcase
   endfunction

   always_comb begin
      a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a_in};
      b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b_in};
      sync_ab  = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
   end

   // A level change is accepted only after FILT_LEN consecutive differing cycles
   always_comb begin
      filt_d = filt_q;
      for (int ch = 0; ch < 2; ch++) begin
         fcnt_d[ch] = '0;
         if (sync_ab[ch] != filt_q[ch]) begin
            if (fcnt_q[ch] == FILT_LAST) begin
               filt_d[ch] = sync_ab[ch];
            end else begin
               fcnt_d[ch] = fcnt_q[ch] + FCNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      delta = gray_idx(filt_q) - gray_idx(prev_q);
      if (RES == 1) begin
         counted = ((prev_q == 2'b00) && (filt_q == 2'b10)) ||
                   ((prev_q == 2'b10) && (filt_q == 2'b00));
      end else if (RES == 2) begin
         counted = prev_q[1] ^ filt_q[1];
      end else begin
         counted = 1'b1;
      end
   end

   // Decode; the init window silently aligns prev with whatever level settles after reset
   always_comb begin
      init_d     = init_q;
      prev_d     = prev_q;
      step_d     = 1'b0;
      err_d      = 1'b0;
      dir_d      = dir_q;
      err_flag_d = err_flag_q;
      pos_d      = pos_q;
      if (init_q != '0) begin
         init_d = init_q - INIT_W'(1);
         prev_d = filt_q;
      end else if (filt_q != prev_q) begin
         prev_d = filt_q;
         if (delta == 2'd2) begin
            err_d      = 1'b1;
            err_flag_d = 1'b1;
         end else begin
            dir_d = (delta == 2'd1);
            if (counted) begin
               step_d = 1'b1;
               pos_d  = (delta == 2'd1) ? pos_q + CNT_WIDTH'(1) : pos_q - CNT_WIDTH'(1);
            end
         end
      end
      if (pos_clr) begin
         pos_d      = '0;
         err_flag_d = err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         a_sync_q   <= '0;
         b_sync_q   <= '0;
         filt_q     <= '0;
         fcnt_q[0]  <= '0;
         fcnt_q[1]  <= '0;
         prev_q     <= '0;
         init_q     <= INIT_VAL;
         step_q     <= 1'b0;
         dir_q      <= 1'b1;
         err_q      <= 1'b0;
         err_flag_q <= 1'b0;
         pos_q      <= '0;
      end else begin
         a_sync_q   <= a_sync_d;
         b_sync_q   <= b_sync_d;
         filt_q     <= filt_d;
         fcnt_q[0]  <= fcnt_d[0];
         fcnt_q[1]  <= fcnt_d[1];
         prev_q     <= prev_d;
         init_q     <= init_d;
         step_q     <= step_d;
         dir_q      <= dir_d;
         err_q      <= err_d;
         err_flag_q <= err_flag_d;
         pos_q      <= pos_d;
      end
   end

   assign step     = step_q;
   assign dir      = dir_q;
   assign err      = err_q;
   assign err_flag = err_flag_q;
   assign pos      = pos_q;

endmodule

// File: tb/tb_qdec.sv
// Bench for qdec: X4 and X1 instances share one randomized A/B stream and are
// compared every cycle against an event-level Gray-code position model.
module tb_qdec;

   localparam int unsigned LAT      = 7;   // edges from an input change to step/pos
   localparam int unsigned FILT_LEN = 4;

   logic        clk = 1'b0;
   logic        sclr, a_in, b_in, pos_clr;
   logic        step4, dir4, err4, flag4;
   logic        step1, dir1, err1, flag1;
   logic [15:0] pos4, pos1;

   qdec #(.SYNC_STAGES(2), .FILT_LEN(FILT_LEN), .MODE("X4"), .CNT_WIDTH(16)) u_x4 (
      .clk(clk), .sclr(sclr), .a_in(a_in), .b_in(b_in), .pos_clr(pos_clr),
      .step(step4), .dir(dir4), .err(err4), .err_flag(flag4), .pos(pos4));

   qdec #(.SYNC_STAGES(2), .FILT_LEN(FILT_LEN), .MODE("X1"), .CNT_WIDTH(16)) u_x1 (
      .clk(clk), .sclr(sclr), .a_in(a_in), .b_in(b_in), .pos_clr(pos_clr),
      .step(step1), .dir(dir1), .err(err1), .err_flag(flag1), .pos(pos1));

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [1:0]  ab;
   } ev_t;

   ev_t         evq[$];
   int unsigned cyc      = 0;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int          gidx [4] = '{0, 3, 1, 2};  // {A,B} value -> index along forward sequence
   logic [1:0]  in_ab;                      // level currently driven and held
   logic [1:0]  dec_ab;                     // level last decoded by the model
   logic        clr_rand;
   logic        e_step4, e_step1, e_err, e_dir, e_flag;
   logic [15:0] e_pos4, e_pos1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      evq.delete();
      e_step4 = 1'b0; e_step1 = 1'b0; e_err = 1'b0;
      e_dir   = 1'b1; e_flag  = 1'b0;
      e_pos4  = '0;   e_pos1  = '0;
      dec_ab  = in_ab;
   endtask

   task automatic model_decode(input logic [1:0] nab);
      int d;
      d = (gidx[nab] - gidx[dec_ab] + 4) % 4;
      if (d == 2) begin
         e_err  = 1'b1;
         e_flag = 1'b1;
      end else if (d != 0) begin
         e_dir   = (d == 1);
         e_step4 = 1'b1;
         e_pos4  = e_pos4 + ((d == 1) ? 16'd1 : 16'hFFFF);
         if ({dec_ab, nab} == 4'b0010 || {dec_ab, nab} == 4'b1000) begin
            e_step1 = 1'b1;
            e_pos1  = e_pos1 + ((d == 1) ? 16'd1 : 16'hFFFF);
         end
      end
      dec_ab = nab;
   endtask

   task automatic tick(input logic clr);
      logic rst;
      logic c;
      ev_t  ev;
      c = clr | (clr_rand && ($urandom_range(0, 15) == 0));
      pos_clr = c;
      rst = sclr;
      @(posedge clk);
      cyc++;
      #1;
      e_step4 = 1'b0; e_step1 = 1'b0; e_err = 1'b0;
      if (rst) begin
         model_reset();
      end else begin
         if (evq.size() > 0 && evq[0].cyc == cyc) begin
            ev = evq.pop_front();
            model_decode(ev.ab);
         end
         if (c) begin
            e_pos4 = '0;
            e_pos1 = '0;
            e_flag = e_err;
         end
      end
      pos_clr = 1'b0;
      check("step_x4", step4, e_step4);
      check("step_x1", step1, e_step1);
      check("err_x4",  err4,  e_err);
      check("err_x1",  err1,  e_err);
      check("dir_x4",  dir4,  e_dir);
      check("dir_x1",  dir1,  e_dir);
      check("flag_x4", flag4, e_flag);
      check("flag_x1", flag1, e_flag);
      check("pos_x4",  pos4,  e_pos4);
      check("pos_x1",  pos1,  e_pos1);
   endtask

   task automatic drive(input logic [1:0] ab, input int unsigned hold);
      if (ab != in_ab) evq.push_back('{cyc: cyc + LAT, ab: ab});
      in_ab = ab;
      a_in  = ab[1];
      b_in  = ab[0];
      repeat (hold) tick(1'b0);
   endtask

   // Flip one channel for fewer than FILT_LEN cycles; it must leave no trace
   task automatic glitch(input int unsigned ch, input int unsigned len);
      if (ch == 1) a_in = ~in_ab[1];
      else         b_in = ~in_ab[0];
      repeat (len) tick(1'b0);
      a_in = in_ab[1];
      b_in = in_ab[0];
      repeat (3) tick(1'b0);
   endtask

   task automatic do_reset(input int unsigned n);
      sclr = 1'b1;
      repeat (n) tick(1'b0);
      sclr = 1'b0;
      repeat (10) tick(1'b0);
   endtask

   logic [1:0] fwd_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   initial begin
      sclr = 1'b1; a_in = 1'b0; b_in = 1'b0; pos_clr = 1'b0;
      in_ab = 2'b00; clr_rand = 1'b0;
      model_reset();
      do_reset(3);

      // Eight forward transitions, 10 cycles apart
      for (int i = 0; i < 8; i++) drive(fwd_seq[(i + 1) % 4], 10);
      check("fwd8_pos", pos4, 16'd8);
      check("fwd8_dir", dir4, 1'b1);

      // Clear, then one backward step wraps below zero
      tick(1'b1);
      drive(2'b01, 10);
      check("wrap_pos", pos4, 16'hFFFF);
      check("wrap_dir", dir4, 1'b0);
      drive(2'b00, 10);

      // Short glitch ignored; FILT_LEN-long pulse counted there and back
      glitch(1, FILT_LEN - 1);
      drive(2'b10, FILT_LEN);
      drive(2'b00, 10);

      // Illegal double change, then clear
      drive(2'b11, 10);
      check("illegal_flag", flag4, 1'b1);
      tick(1'b1);
      check("clr_flag", flag4, 1'b0);
      check("clr_pos", pos4, 16'd0);
      drive(2'b01, 10);
      drive(2'b00, 10);

      // Full forward cycle then one step back (X1 counts only at 00<->10)
      for (int i = 1; i <= 4; i++) drive(fwd_seq[i % 4], 10);
      drive(2'b10, 10);
      drive(2'b00, 10);

      // pos_clr landing on the step edge, then on the err edge
      drive(2'b10, LAT - 1);
      tick(1'b1);
      repeat (4) tick(1'b0);
      drive(2'b01, LAT - 1);
      tick(1'b1);
      repeat (4) tick(1'b0);
      drive(2'b11, 10);

      // Inputs held at 11 across a reset pulse: no spurious event
      do_reset(2);
      check("hold11_pos", pos4, 16'd0);
      drive(2'b01, 10);
      check("hold11_step_pos", pos4, 16'd1);

      // Reset while a change is still in flight
      drive(2'b00, 3);
      do_reset(2);

      // Randomized walk with glitches and sporadic clears
      clr_rand = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) glitch($urandom_range(0, 1), $urandom_range(1, FILT_LEN - 1));
         drive(2'($urandom_range(0, 3)), $urandom_range(FILT_LEN + 1, 14));
      end
      clr_rand = 1'b0;
      repeat (12) tick(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
